// File: rtl/opb_event_counter_bank.sv
// opb_event_counter_bank: bank of C_NUM_CH per-cycle event counters on an OPB
// slave port, with per-channel enable mask, atomic snapshot, bulk clear and
// sticky overflow flags (write-1-to-clear).
// Optional build macro OPB_CNT_BANK_IRQ_EN adds an IRQEN register at word
// offset 0x4C and a registered irq output; without it 0x4C reads as zero.
module opb_event_counter_bank #(
  parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR  = 32'h0000_00FF,
  parameter int          C_NUM_CH    = 4,
  parameter int          C_CNT_WIDTH = 32,
  parameter int          C_SATURATE  = 0
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst_n,
  input  logic [0:31]         OPB_ABus,
  input  logic [0:3]          OPB_BE,
  input  logic [0:31]         OPB_DBus,
  input  logic                OPB_RNW,
  input  logic                OPB_select,
  input  logic                OPB_seqAddr,
  output logic [0:31]         Sl_DBus,
  output logic                Sl_xferAck,
  output logic                Sl_errAck,
  output logic                Sl_retry,
  output logic                Sl_toutSup,
  input  logic [C_NUM_CH-1:0] user_event_in
`ifdef OPB_CNT_BANK_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  localparam logic [5:0] W_CTRL  = 6'h10;
  localparam logic [5:0] W_OVF   = 6'h11;
  localparam logic [5:0] W_EN    = 6'h12;
  localparam logic [5:0] W_IRQEN = 6'h13;

  // OPB bit 31 is the LSB, so a plain MSB-to-MSB copy yields conventional
  // little-endian vectors for internal arithmetic.
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] off;
  logic [5:0]  word;
  logic        hit;

  assign addr  = OPB_ABus;
  assign wdata = OPB_DBus;
  // Offset compare against the span avoids a separate lower-bound compare:
  // addresses below the base wrap to a huge offset and miss.
  assign off   = addr - C_BASEADDR;
  assign word  = off[7:2];
  assign hit   = OPB_select && (off <= SPAN);

  logic ack_q, ack_d;
  logic [31:0] dbus_q, dbus_d;

  logic [C_CNT_WIDTH-1:0] cnt_q  [C_NUM_CH];
  logic [C_CNT_WIDTH-1:0] cnt_d  [C_NUM_CH];
  logic [C_CNT_WIDTH-1:0] snap_q [C_NUM_CH];
  logic [C_NUM_CH-1:0]    ovf_q, ovf_d, ovf_set;
  logic [C_NUM_CH-1:0]    en_q, en_d;
  logic [C_NUM_CH-1:0]    wmask;

  logic wr_en, ctrl_wr, snap_now, clr_now, ovf_wr, en_wr;

  // Writes take effect in the ack cycle while the master still drives the bus.
  assign wr_en    = ack_q && !OPB_RNW;
  assign ctrl_wr  = wr_en && (word == W_CTRL);
  assign snap_now = ctrl_wr && wdata[0];
  assign clr_now  = ctrl_wr && wdata[1];
  assign ovf_wr   = wr_en && (word == W_OVF);
  assign en_wr    = wr_en && (word == W_EN);

`ifdef OPB_CNT_BANK_IRQ_EN
  logic [C_NUM_CH-1:0] irqen_q, irqen_d;
  logic                irq_q, irq_d;
  logic                irqen_wr;

  assign irqen_wr = wr_en && (word == W_IRQEN);
  assign irq      = irq_q;
`endif

  // Channel i lives at bit (31-i) of a bus word.
  function automatic logic [31:0] mask_to_word(input logic [C_NUM_CH-1:0] m);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < C_NUM_CH; i++) w[31-i] = m[i];
    return w;
  endfunction

  // Right-justify and zero-extend a counter value.
  function automatic logic [31:0] cnt_to_word(input logic [C_CNT_WIDTH-1:0] c);
    logic [31:0] w;
    w = '0;
    w[C_CNT_WIDTH-1:0] = c;
    return w;
  endfunction

  // Extract the per-channel mask from the write data.
  always_comb begin
    wmask = '0;
    for (int i = 0; i < C_NUM_CH; i++) wmask[i] = wdata[31-i];
  end

  // Counter next state: clear beats events; overflow wraps or saturates.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_now) begin
        cnt_d[i] = '0;
      end else if (user_event_in[i] && en_q[i]) begin
        if (&cnt_q[i]) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = (C_SATURATE != 0) ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + C_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Flag and mask next state; a hardware overflow set beats a software clear.
  always_comb begin
    ovf_d = (ovf_q & ~(ovf_wr ? wmask : '0)) | ovf_set;
    en_d  = en_wr ? wmask : en_q;
`ifdef OPB_CNT_BANK_IRQ_EN
    irqen_d = irqen_wr ? wmask : irqen_q;
    irq_d   = |(ovf_q & irqen_q);
`endif
  end

  // Read mux and single-cycle acknowledge generation.
  always_comb begin
    logic [31:0] rdata;
    rdata = '0;
    for (int i = 0; i < C_NUM_CH; i++) begin
      if (word == 6'(i)) rdata = cnt_to_word(snap_q[i]);
    end
    case (word)
      W_OVF:   rdata = mask_to_word(ovf_q);
      W_EN:    rdata = mask_to_word(en_q);
`ifdef OPB_CNT_BANK_IRQ_EN
      W_IRQEN: rdata = mask_to_word(irqen_q);
`endif
      default: ;
    endcase
    ack_d  = hit && !ack_q;
    dbus_d = (hit && !ack_q && OPB_RNW) ? rdata : '0;
  end

  // Bus-side registers; reset drops an in-flight ack immediately.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      ack_q  <= ack_d;
      dbus_q <= dbus_d;
    end
  end

  // Counters, snapshots (pre-update values), flags and masks.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q <= '0;
      en_q  <= '1;
`ifdef OPB_CNT_BANK_IRQ_EN
      irqen_q <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_now) snap_q[i] <= cnt_q[i];
      end
      ovf_q <= ovf_d;
      en_q  <= en_d;
`ifdef OPB_CNT_BANK_IRQ_EN
      irqen_q <= irqen_d;
      irq_q   <= irq_d;
`endif
    end
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{OPB_BE, OPB_seqAddr, off[31:8], off[1:0], wdata};

endmodule

// File: tb/tb_opb_event_counter_bank.sv
// Directed bench for opb_event_counter_bank. Three instances share one bus:
// A = 32-bit wrapping, B = 4-bit wrapping, C = 4-bit saturating.
// Build with OPB_CNT_BANK_IRQ_EN defined to exercise the irq path.
module tb_opb_event_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] abus, dbus;
  logic [3:0]  be;
  logic        rnw, sel, seq;
  logic [3:0]  ev;

  logic [31:0] dA, dB, dC;
  logic        ackA, ackB, ackC;
  logic        errA, errB, errC, rtyA, rtyB, rtyC, toA, toB, toC;
`ifdef OPB_CNT_BANK_IRQ_EN
  logic        irqA, irqB, irqC;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rA, rB, rC;

  always #5 clk = ~clk;

  opb_event_counter_bank #(.C_NUM_CH(4), .C_CNT_WIDTH(32), .C_SATURATE(0)) u_a (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dA), .Sl_xferAck(ackA),
    .Sl_errAck(errA), .Sl_retry(rtyA), .Sl_toutSup(toA), .user_event_in(ev)
`ifdef OPB_CNT_BANK_IRQ_EN
    , .irq(irqA)
`endif
  );

  opb_event_counter_bank #(.C_NUM_CH(4), .C_CNT_WIDTH(4), .C_SATURATE(0)) u_b (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dB), .Sl_xferAck(ackB),
    .Sl_errAck(errB), .Sl_retry(rtyB), .Sl_toutSup(toB), .user_event_in(ev)
`ifdef OPB_CNT_BANK_IRQ_EN
    , .irq(irqB)
`endif
  );

  opb_event_counter_bank #(.C_NUM_CH(4), .C_CNT_WIDTH(4), .C_SATURATE(1)) u_c (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(dC), .Sl_xferAck(ackC),
    .Sl_errAck(errC), .Sl_retry(rtyC), .Sl_toutSup(toC), .user_event_in(ev)
`ifdef OPB_CNT_BANK_IRQ_EN
    , .irq(irqC)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One OPB transfer; evm is driven on user_event_in during the ack cycle.
  task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] evm);
    int lat;
    @(negedge clk);
    sel = 1'b1; rnw = r; abus = a; dbus = d; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ackA && lat < 8);
    chk("ack_latency", 32'(lat), 32'd1);
    rA = dA; rB = dB; rC = dC;
    ev = evm;
    @(posedge clk); #1;
    ev = '0; sel = 1'b0; rnw = 1'b1;
    chk("ack_single", {31'b0, ackA}, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    xfer(1'b1, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b0, a, d, 4'h0);
  endtask

  task automatic pulse(input logic [3:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); ev = m;
      @(negedge clk); ev = '0;
    end
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; sel = 1'b0; rnw = 1'b1; abus = '0; dbus = '0;
    be = 4'hF; seq = 1'b0; ev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ackA}, 32'd0);
    chk("rst_dbus", dA, 32'h0);
    chk("tied_outs", {29'b0, errA, rtyA, toA}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset state of registers
    rd(32'h00); chk("rst_snap0", rA, 32'h0);
    rd(32'h44); chk("rst_ovf", rA, 32'h0);
    rd(32'h48); chk("rst_en", rA, 32'hF000_0000);

    // Basic counting on ch2 with snapshot
    pulse(4'b0100, 5);
    wr(32'h40, 32'h1);
    rd(32'h08); chk("snap2_5", rA, 32'd5);
    rd(32'h00); chk("snap0_0", rA, 32'd0);

    // Overflow: 17 events on ch0
    wr(32'h40, 32'h2);
    pulse(4'b0001, 17);
    wr(32'h40, 32'h1);
    rd(32'h00);
    chk("ovf_a_cnt", rA, 32'd17);
    chk("wrap_b_cnt", rB, 32'd1);
    chk("sat_c_cnt", rC, 32'hF);
    rd(32'h44);
    chk("ovf_a_flag", rA, 32'h0);
    chk("ovf_b_flag", rB, 32'h8000_0000);
    chk("ovf_c_flag", rC, 32'h8000_0000);
    wr(32'h44, 32'h8000_0000);
    rd(32'h44);
    chk("w1c_b", rB, 32'h0);
    chk("w1c_c", rC, 32'h0);

    // SNAP+CLEAR with coincident ch1 event
    wr(32'h40, 32'h2);
    pulse(4'b0010, 3);
    xfer(1'b0, 32'h40, 32'h3, 4'b0010);
    rd(32'h04); chk("snapclr_pre", rA, 32'd3);
    wr(32'h40, 32'h1);
    rd(32'h04); chk("clr_wins_evt", rA, 32'd0);

    // SNAP excludes coincident event on ch3
    pulse(4'b1000, 2);
    xfer(1'b0, 32'h40, 32'h1, 4'b1000);
    rd(32'h0C); chk("snap_pre_evt", rA, 32'd2);
    wr(32'h40, 32'h1);
    rd(32'h0C); chk("snap_post_evt", rA, 32'd3);

    // Enable mask
    wr(32'h48, 32'h0);
    rd(32'h48); chk("en_zero", rA, 32'h0);
    pulse(4'b0011, 4);
    wr(32'h40, 32'h1);
    rd(32'h00); chk("en_drop", rA, 32'd0);
    wr(32'h48, 32'h8000_0000);
    rd(32'h48); chk("en_ch0", rA, 32'h8000_0000);
    pulse(4'b0011, 2);
    wr(32'h40, 32'h1);
    rd(32'h00); chk("en_ch0_cnt", rA, 32'd2);
    rd(32'h04); chk("en_ch1_off", rA, 32'd0);

    // Map corners
    rd(32'h40); chk("ctrl_reads0", rA, 32'h0);
    wr(32'h00, 32'h1234);
    rd(32'h00); chk("snap_ro", rA, 32'd2);
    rd(32'h10); chk("snap_beyond_ch", rA, 32'h0);
    rd(32'h50); chk("unmapped", rA, 32'h0);
    wr(32'h4C, 32'hFFFF_FFFF);
    rd(32'h4C);
`ifdef OPB_CNT_BANK_IRQ_EN
    chk("irqen_rw", rA, 32'hF000_0000);
    wr(32'h4C, 32'h0);
`else
    chk("irqen_absent", rA, 32'h0);
`endif

    // Address outside the window gets no ack
    @(negedge clk);
    sel = 1'b1; rnw = 1'b1; abus = 32'h100; seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ackA) seen = 1'b1;
    end
    chk("no_hit_ack", {31'b0, seen}, 32'd0);
    @(negedge clk); sel = 1'b0;

    // Hardware overflow set beats coincident W1C
    wr(32'h48, 32'hF000_0000);
    wr(32'h40, 32'h2);
    pulse(4'b0001, 31);
    xfer(1'b0, 32'h44, 32'h8000_0000, 4'b0001);
    rd(32'h44);
    chk("set_wins_a", rA, 32'h0);
    chk("set_wins_b", rB, 32'h8000_0000);
    chk("set_wins_c", rC, 32'h8000_0000);
    wr(32'h44, 32'h8000_0000);
    rd(32'h44); chk("w1c_after", rB, 32'h0);

`ifdef OPB_CNT_BANK_IRQ_EN
    wr(32'h4C, 32'h8000_0000);
    wr(32'h40, 32'h2);
    pulse(4'b0001, 15);
    chk("irq_idle", {31'b0, irqB}, 32'd0);
    @(negedge clk); ev = 4'b0001;
    @(posedge clk); #1; ev = '0;
    chk("irq_lag", {31'b0, irqB}, 32'd0);
    @(posedge clk); #1;
    chk("irq_set", {31'b0, irqB}, 32'd1);
    wr(32'h44, 32'h8000_0000);
    chk("irq_hold", {31'b0, irqB}, 32'd1);
    @(posedge clk); #1;
    chk("irq_clr", {31'b0, irqB}, 32'd0);
`endif

    // Reset in the middle of a write
    wr(32'h48, 32'h3000_0000);
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = 32'h48; dbus = 32'h0;
    @(posedge clk); #1;
    chk("mid_ack_up", {31'b0, ackA}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_drop", {31'b0, ackA}, 32'd0);
    sel = 1'b0; rnw = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    rd(32'h48); chk("mid_en_reset", rA, 32'hF000_0000);
    rd(32'h00); chk("mid_snap_reset", rA, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
